ahfp_mul_pipe: RTL and testbench
================================

// Module: ahfp_mul_pipe
// PURPOSE
//  Pipelined IEEE-754 single-precision multiplier with valid tracking. Sits directly
//  downstream of ahfp_sub_multi: consumes its difference as dataa, scale factor as datab.
//  Accepts one operand pair per enabled cycle; fixed latency; no back-pressure, clk_en only.
// PARAMETERS
//  LATENCY    3   pipeline depth in enabled cycles; fixed, the only legal value
//  FLUSH_DEN  1   1 = denormal inputs/outputs flushed to signed zero; 0 is not supported
// PORTS
//  clk        in   1   rising-edge clock, single clock domain
//  rst_n      in   1   asynchronous active-low reset
//  clk_en     in   1   1 = pipeline advances; 0 = every register holds
//  in_valid   in   1   dataa/datab carry a real operand pair this cycle
//  dataa      in   32  IEEE-754 single operand A (sub stage result)
//  datab      in   32  IEEE-754 single operand B
//  result     out  32  registered product A*B
//  out_valid  out  1   result corresponds to the in_valid pair LATENCY enabled cycles earlier
// BEHAVIOUR
//  Reset: rst_n low asynchronously clears all stage regs; result=32'h0, out_valid=0.
//   Reset mid-operation discards in-flight pairs; no partial result ever reaches the output.
//  Timing: pair sampled at edge k with clk_en=1 -> result/out_valid at edge k+3 (enabled
//   edges only). Throughput 1/cycle. Bubbles (in_valid=0) propagate as out_valid=0; result
//   then holds a don't-care value that must still be deterministic (no X).
//  clk_en=0: all regs, including valid bits, hold; outputs stay stable for the stall.
//  S1: unpack; classify (zero/denorm/inf/nan); sign=sa^sb; exp_sum=ea+eb-127 in 10-bit
//   signed; 24x24 -> 48-bit mantissa product (hidden bit restored).
//  S2: normalise: prod[47]=1 -> shift right 1, exp+1; guard/round/sticky from dropped bits;
//   round-to-nearest-even; mantissa carry-out from rounding -> exp+1, mantissa=0.
//  S3: pack + specials, priority order:
//   1) either NaN, or 0*inf          -> 32'h7FC00000 (canonical qNaN, sign ignored)
//   2) either inf                    -> {sign,8'hFF,23'h0}
//   3) either zero/denorm input      -> {sign,31'h0}
//   4) exp >= 255 after rounding     -> {sign,8'hFF,23'h0} (overflow)
//   5) exp <= 0 after rounding       -> {sign,31'h0} (underflow flush)
//   6) otherwise normal {sign,exp[7:0],mant[22:0]}
//  Signed zero kept: -0*+x = 32'h80000000. Exponent arithmetic never wraps (10-bit range).
// STRUCTURE
//  ahfp_pkg: FP_BIAS=127, FP_EXP_W=8, FP_MAN_W=23, FP_QNAN=32'h7FC00000, FP_INF_EXP=8'hFF,
//   class encoding localparams (CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN), shared with
//   ahfp_sub_multi.
//  Sub-module ahfp_classify: combinational 32-bit -> {class, sign, exp, 24-bit mantissa};
//   instantiated twice in S1, also reusable by the sub stage.
//  Three explicit stage register banks, each with its own valid bit, gated by clk_en.
// TESTING
//  Basic: 3F800000*40000000 -> 40000000; BF800000*40400000 -> C0400000, out_valid 3 edges later.
//  Rounding: 3F800001*3F800001 -> 3F800002 (RNE); 3FC00000*3FC00000 -> 40100000 (normalise).
//  Specials: 00000000*7F800000 -> 7FC00000; 7F7FFFFF*40000000 -> 7F800000;
//   00800000*3F000000 -> 00000000; 80000000*3F800000 -> 80000000.
//  Streaming: 10 back-to-back pairs incl. sub-stage outputs (BF800000*3F000000 -> BF000000)
//   -> 10 consecutive out_valid, in order, matching reference model.
//  Stall/bubble: clk_en low 4 cycles mid-stream -> outputs frozen, no pair lost/duplicated;
//   in_valid gaps reproduce the same gaps on out_valid.
//  Reset: assert rst_n low with 3 pairs in flight -> result=0, out_valid=0 immediately
//   (async); after release first out_valid only 3 enabled edges after a new pair.

Source files
------------

// File: rtl/ahfp_pkg.sv
// ahfp_pkg: single-precision field widths, special encodings and operand classes shared by the ahfp stages
package ahfp_pkg;
  localparam int FP_BIAS = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [FP_EXP_W-1:0] FP_INF_EXP = 8'hFF;
  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_NORM = 2'd1;
  localparam logic [1:0] CLS_INF = 2'd2;
  localparam logic [1:0] CLS_NAN = 2'd3;
  typedef struct packed {
    logic [1:0] cls;
    logic sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W:0] man;
  } fp_unpk_t;
endpackage

// File: rtl/ahfp_classify.sv
// ahfp_classify: unpacks a single-precision word; denormals are reported as zero (flush-to-zero)
module ahfp_classify
  import ahfp_pkg::*;
(
  input  logic [31:0] x,
  output fp_unpk_t    u
);
  logic [FP_EXP_W-1:0] e;
  logic f_nz;
  assign e = x[30:23];
  assign f_nz = |x[22:0];
  always_comb begin
    u.sign = x[31];
    u.exp = e;
    u.man = {|e, x[22:0]};
    u.cls = (e == '0) ? CLS_ZERO : (e == FP_INF_EXP) ? (f_nz ? CLS_NAN : CLS_INF) : CLS_NORM;
  end
endmodule

// File: rtl/ahfp_mul_pipe.sv
// ahfp_mul_pipe: three-stage IEEE-754 single multiplier (multiply, normalise/round, pack) with valid tracking
module ahfp_mul_pipe
  import ahfp_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int FLUSH_DEN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        in_valid,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        out_valid
);
  if (LATENCY != 3 || FLUSH_DEN != 1) begin : g_cfg
    $error("ahfp_mul_pipe supports only LATENCY=3 and FLUSH_DEN=1");
  end
  fp_unpk_t ua, ub;
  ahfp_classify u_cls_a (.x(dataa), .u(ua));
  ahfp_classify u_cls_b (.x(datab), .u(ub));
  logic a_zero, b_zero, a_inf, b_inf;
  logic nan0, inf0, zero0;
  logic signed [9:0] e_sum;
  logic [47:0] prod;
  assign a_zero = ua.cls == CLS_ZERO;
  assign b_zero = ub.cls == CLS_ZERO;
  assign a_inf = ua.cls == CLS_INF;
  assign b_inf = ub.cls == CLS_INF;
  assign nan0 = (ua.cls == CLS_NAN) | (ub.cls == CLS_NAN) | (a_zero & b_inf) | (a_inf & b_zero);
  assign inf0 = a_inf | b_inf;
  assign zero0 = a_zero | b_zero;
  assign e_sum = 10'({2'b0, ua.exp} + {2'b0, ub.exp} - 10'(FP_BIAS));
  assign prod = 48'(ua.man) * 48'(ub.man);
  logic s1_v, s1_sign, s1_nan, s1_inf, s1_zero;
  logic signed [9:0] s1_exp;
  logic [47:0] s1_prod;
  logic hi, g, st, rnd;
  logic [23:0] m24;
  logic [24:0] m25;
  logic signed [9:0] e_n;
  assign hi = s1_prod[47];
  assign m24 = hi ? s1_prod[47:24] : s1_prod[46:23];
  assign g = hi ? s1_prod[23] : s1_prod[22];
  assign st = hi ? |s1_prod[22:0] : |s1_prod[21:0];
  assign rnd = g & (st | m24[0]);
  assign m25 = {1'b0, m24} + 25'(rnd);
  assign e_n = s1_exp + 10'(hi) + 10'(m25[24]);
  logic s2_v, s2_sign, s2_nan, s2_inf, s2_zero;
  logic signed [9:0] s2_exp;
  logic [FP_MAN_W-1:0] s2_frac;
  logic [31:0] res_n;
  // no leading one after rounding can only come from a flushed operand
  always_comb begin
    res_n = s2_nan ? FP_QNAN
          : s2_inf ? {s2_sign, FP_INF_EXP, 23'h0}
          : s2_zero ? {s2_sign, 31'h0}
          : (s2_exp >= 10'sd255) ? {s2_sign, FP_INF_EXP, 23'h0}
          : (s2_exp <= 10'sd0) ? {s2_sign, 31'h0}
          : {s2_sign, s2_exp[7:0], s2_frac};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_sign <= 1'b0;
      s1_nan <= 1'b0;
      s1_inf <= 1'b0;
      s1_zero <= 1'b0;
      s1_exp <= '0;
      s1_prod <= '0;
      s2_v <= 1'b0;
      s2_sign <= 1'b0;
      s2_nan <= 1'b0;
      s2_inf <= 1'b0;
      s2_zero <= 1'b0;
      s2_exp <= '0;
      s2_frac <= '0;
      out_valid <= 1'b0;
      result <= '0;
    end else if (clk_en) begin
      s1_v <= in_valid;
      s1_sign <= ua.sign ^ ub.sign;
      s1_nan <= nan0;
      s1_inf <= inf0;
      s1_zero <= zero0;
      s1_exp <= e_sum;
      s1_prod <= prod;
      s2_v <= s1_v;
      s2_sign <= s1_sign;
      s2_nan <= s1_nan;
      s2_inf <= s1_inf;
      s2_zero <= s1_zero | ~(m25[24] | m25[23]);
      s2_exp <= e_n;
      s2_frac <= m25[22:0];
      out_valid <= s2_v;
      result <= res_n;
    end
  end
endmodule

// File: tb/tb_ahfp_mul_pipe.sv
// tb_ahfp_mul_pipe: directed and streamed operand pairs checked against a double-precision reference through a scoreboard
module tb_ahfp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;
  logic in_valid = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic [31:0] result;
  logic out_valid;
  ahfp_mul_pipe dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid),
    .dataa(dataa), .datab(datab), .result(result), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] r; int due; } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  logic en_s;
  logic [31:0] last_res;
  logic last_v;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask
  // exact product in double precision, then rounded to single by hand (RNE)
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic na, nb, ia, ib, za, zb, s;
    logic [63:0] d;
    logic [24:0] m;
    real pr;
    int e;
    na = a[30:23] == 8'hFF && a[22:0] != 0;
    nb = b[30:23] == 8'hFF && b[22:0] != 0;
    ia = a[30:23] == 8'hFF && a[22:0] == 0;
    ib = b[30:23] == 8'hFF && b[22:0] == 0;
    za = a[30:23] == 8'h00;
    zb = b[30:23] == 8'h00;
    s = a[31] ^ b[31];
    if (na || nb || (za && ib) || (ia && zb)) return 32'h7FC00000;
    if (ia || ib) return {s, 8'hFF, 23'h0};
    if (za || zb) return {s, 31'h0};
    pr = $bitstoreal({1'b0, {3'b0, a[30:23]} + 11'd896, a[22:0], 29'h0})
       * $bitstoreal({1'b0, {3'b0, b[30:23]} + 11'd896, b[22:0], 29'h0});
    d = $realtobits(pr);
    e = int'(d[62:52]) - 896;
    m = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) e++;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), m[22:0]};
  endfunction
  function automatic logic [31:0] rnd_norm();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
    @(negedge clk);
    clk_en = 1'b1;
    in_valid = v;
    dataa = a;
    datab = b;
    if (v) q.push_back('{want, en_cnt + 3});
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, a, b, ref_mul(a, b));
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) drive(1'b0, 32'($urandom), 32'($urandom), '0);
    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL drain observed=%0d pending expected=0", q.size());
    end
  endtask
  always @(posedge clk) begin
    en_s = clk_en;
    #1;
    if (rst_n) begin
      if (en_s) begin
        en_cnt++;
        chk("no_x", 32'($isunknown(result)), 32'd0);
        if (out_valid) begin
          total++;
          assert (q.size() > 0) else begin
            bad++;
            $error("FAIL spurious observed=out_valid expected=idle");
          end
          if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("result", result, e.r);
            chk("latency", 32'(en_cnt), 32'(e.due));
          end
        end else if (q.size() > 0 && q[0].due <= en_cnt) begin
          total++;
          assert (0) else begin
            bad++;
            $error("FAIL missing observed=idle expected=%h at edge %0d", q[0].r, q[0].due);
          end
          void'(q.pop_front());
        end
      end else begin
        chk("stall_result", result, last_res);
        chk("stall_valid", 32'(out_valid), 32'(last_v));
      end
      last_res = result;
      last_v = out_valid;
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_result", result, 32'h0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 32'h3F800000, 32'h40000000, 32'h40000000);
    drive(1'b1, 32'hBF800000, 32'h40400000, 32'hC0400000);
    drive(1'b1, 32'h3F800001, 32'h3F800001, 32'h3F800002);
    drive(1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    drive(1'b1, 32'h00000000, 32'h7F800000, 32'h7FC00000);
    drive(1'b1, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000);
    drive(1'b1, 32'h00800000, 32'h3F000000, 32'h00000000);
    drive(1'b1, 32'h80000000, 32'h3F800000, 32'h80000000);
    drive(1'b1, 32'hFFC00001, 32'h3F800000, 32'h7FC00000);
    drive(1'b1, 32'hFF800000, 32'hC0000000, 32'h7F800000);
    drive(1'b1, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
    drive(1'b1, 32'h80400000, 32'h7F000000, 32'h80000000);
    drive(1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    drain();
    for (int i = 0; i < 5; i++) send(rnd_norm(), rnd_norm());
    repeat (4) begin
      @(negedge clk);
      clk_en = 1'b0;
      in_valid = 1'b1;
      dataa = 32'($urandom);
      datab = 32'($urandom);
    end
    drive(1'b1, 32'hBF800000, 32'h3F000000, 32'hBF000000);
    for (int i = 0; i < 4; i++) send(rnd_norm(), rnd_norm());
    send(rnd_norm(), rnd_norm());
    drive(1'b0, 32'($urandom), 32'($urandom), '0);
    send(rnd_norm(), rnd_norm());
    send(rnd_norm(), rnd_norm());
    repeat (2) drive(1'b0, 32'($urandom), 32'($urandom), '0);
    send(rnd_norm(), rnd_norm());
    drain();
    for (int i = 0; i < 5; i++) send(rnd_norm(), rnd_norm());
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", result, 32'h0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 32'($urandom), 32'($urandom), '0);
    drive(1'b1, 32'h40400000, 32'hC0800000, 32'hC1400000);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
